// File: rtl/sha256_bs_pkg.sv
// Shared types and constants for the bit-serial SHA-256 datapath stages.
package sha256_bs_pkg;

    localparam int W_WORD = 32;
    localparam int CNT_W  = $clog2(W_WORD);

    typedef logic [W_WORD-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: phase counter, registered bclk and last-phase strobe.
// bclk is low for the first half of each period and high for the second, so
// the falling edge lines up with the point where a source changes its bit.
// restart forces phase 0 next cycle; with en low the generator parks at phase 0
// with bclk low.
module bclk_gen #(
    parameter int clk_div = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic bclk,
    output logic last
);

    localparam int PW = (clk_div > 2) ? $clog2(clk_div) : 1;
    localparam logic [PW-1:0] HALF   = PW'(clk_div / 2);
    localparam logic [PW-1:0] LAST_P = PW'(clk_div - 1);

    if (clk_div < 2 || (clk_div % 2) != 0) begin : g_bad_clk_div
        $error("bclk_gen: clk_div must be even and >= 2");
    end

    logic [PW-1:0] ph_q, ph_d;
    logic          bclk_q, bclk_d;

    // Next phase and the bclk level that belongs to it.
    always_comb begin
        ph_d   = '0;
        bclk_d = 1'b0;
        if (restart) begin
            ph_d   = '0;
            bclk_d = 1'b0;
        end else if (en) begin
            ph_d   = (ph_q == LAST_P) ? '0 : ph_q + 1'b1;
            bclk_d = (ph_d >= HALF);
        end
    end

    // Phase and bclk registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q   <= '0;
            bclk_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    assign last = (ph_q == LAST_P);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the bit-serial SHA-256 stages.
// Handshake: a word is taken in any cycle where word_valid && word_ready;
// word_ready depends only on registered state, and a word offered while
// word_ready is low is simply not taken (no buffering beyond the active word).
// The next word may be taken in the last cycle of the current one, so bclk
// runs without a gap across back-to-back words.
module word_serializer
    import sha256_bs_pkg::*;
#(
    parameter int w_word    = W_WORD,
    parameter int clk_div   = 4,
    parameter bit msb_first = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [w_word-1:0]           word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        bclk,
    output logic [$clog2(w_word)-1:0]   counter,
    output logic                        bit_out,
    output logic                        busy,
    output logic                        word_done
);

    localparam int CW = $clog2(w_word);
    localparam logic [CW-1:0] CNT_LAST = CW'(w_word - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      counter_q, counter_d;
    logic               bit_out_q, bit_out_d;
    logic [w_word-1:0]  shreg_q, shreg_d;

    logic gen_en, gen_restart, ph_last;
    logic end_word, accept;

    bclk_gen #(.clk_div(clk_div)) u_bclk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (gen_en),
        .restart (gen_restart),
        .bclk    (bclk),
        .last    (ph_last)
    );

    assign end_word   = (state_q == SHIFT) && ph_last && (counter_q == CNT_LAST);
    assign word_ready = (state_q == IDLE) || end_word;
    assign accept     = word_valid && word_ready;

    // Load on accept, otherwise advance the bit at the end of each period.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        bit_out_d   = bit_out_q;
        shreg_d     = shreg_q;
        gen_en      = 1'b0;
        gen_restart = 1'b0;
        if (accept) begin
            state_d     = SHIFT;
            counter_d   = '0;
            gen_restart = 1'b1;
            if (msb_first) begin
                bit_out_d = word_in[w_word-1];
                shreg_d   = word_in << 1;
            end else begin
                bit_out_d = word_in[0];
                shreg_d   = word_in >> 1;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (end_word) begin
                        state_d   = IDLE;
                        counter_d = '0;
                        bit_out_d = 1'b0;
                        shreg_d   = '0;
                    end else begin
                        gen_en = 1'b1;
                        if (ph_last) begin
                            counter_d = counter_q + 1'b1;
                            if (msb_first) begin
                                bit_out_d = shreg_q[w_word-1];
                                shreg_d   = shreg_q << 1;
                            end else begin
                                bit_out_d = shreg_q[0];
                                shreg_d   = shreg_q >> 1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, bit index, output bit and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            bit_out_q <= 1'b0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            bit_out_q <= bit_out_d;
            shreg_q   <= shreg_d;
        end
    end

    assign counter   = counter_q;
    assign bit_out   = bit_out_q;
    assign busy      = (state_q == SHIFT);
    assign word_done = end_word;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one instance at 32/4/msb-first and one
// at 32/2/lsb-first, checked every cycle against a small bit-period model.
module tb_word_serializer;
    import sha256_bs_pkg::*;

    logic       clk = 1'b0;
    logic       rst;

    word_t      word_in1, word_in2;
    logic       word_valid1, word_valid2;
    logic       word_ready1, word_ready2;
    logic       bclk1, bclk2;
    cnt_t       counter1, counter2;
    logic       bit_out1, bit_out2;
    logic       busy1, busy2;
    logic       word_done1, word_done2;

    int         total = 0;
    int         bad = 0;
    int         rise_cnt;
    int         done_cnt;
    logic       prev_bclk;
    word_t      cap1;

    always #5 clk = ~clk;

    word_serializer #(.w_word(32), .clk_div(4), .msb_first(1'b1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in1),
        .word_valid (word_valid1),
        .word_ready (word_ready1),
        .bclk       (bclk1),
        .counter    (counter1),
        .bit_out    (bit_out1),
        .busy       (busy1),
        .word_done  (word_done1)
    );

    word_serializer #(.w_word(32), .clk_div(2), .msb_first(1'b0)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in2),
        .word_valid (word_valid2),
        .word_ready (word_ready2),
        .bclk       (bclk2),
        .counter    (counter2),
        .bit_out    (bit_out2),
        .busy       (busy2),
        .word_done  (word_done2)
    );

    // Downstream-style capture: record bit_out at each rising bclk by index.
    always @(posedge bclk1) begin
        cap1[31 - int'(counter1)] <= bit_out1;
    end

    function automatic word_t rotl7(input word_t x);
        return {x[24:0], x[31:25]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input word_t w);
        if (sel == 0) begin
            word_valid1 = v;
            word_in1    = w;
        end else begin
            word_valid2 = v;
            word_in2    = w;
        end
    endtask

    // Offer a word while idle; returns at the sample point of cycle A+1.
    task automatic send(input int sel, input word_t w);
        drive(sel, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input int sel, input string tag);
        if (sel == 0) begin
            chk({tag, "_bclk"}, 32'(bclk1), 32'd0);
            chk({tag, "_cnt"}, 32'(counter1), 32'd0);
            chk({tag, "_bit"}, 32'(bit_out1), 32'd0);
            chk({tag, "_busy"}, 32'(busy1), 32'd0);
            chk({tag, "_done"}, 32'(word_done1), 32'd0);
            chk({tag, "_ready"}, 32'(word_ready1), 32'd1);
        end else begin
            chk({tag, "_bclk"}, 32'(bclk2), 32'd0);
            chk({tag, "_cnt"}, 32'(counter2), 32'd0);
            chk({tag, "_bit"}, 32'(bit_out2), 32'd0);
            chk({tag, "_busy"}, 32'(busy2), 32'd0);
            chk({tag, "_done"}, 32'(word_done2), 32'd0);
            chk({tag, "_ready"}, 32'(word_ready2), 32'd1);
        end
    endtask

    // Check each cycle of a word from A+1 on. At stall_at a new word is offered.
    task automatic run_word(input int sel, input word_t w, input int div, input bit msb,
                            input int stall_at, input word_t nxt, input int stop_at,
                            input string tag);
        for (int i = 0; i < stop_at; i++) begin
            int   cnt;
            int   ph;
            logic exp_bit;
            logic ob, ob_bit, ob_done, ob_ready, ob_busy;
            cnt_t oc;
            cnt = i / div;
            ph  = i % div;
            exp_bit = msb ? w[31 - cnt] : w[cnt];
            if (i == 0) drive(sel, 1'b0, '0);
            if (i == stall_at) drive(sel, 1'b1, nxt);
            if (sel == 0) begin
                ob = bclk1; oc = counter1; ob_bit = bit_out1;
                ob_done = word_done1; ob_ready = word_ready1; ob_busy = busy1;
            end else begin
                ob = bclk2; oc = counter2; ob_bit = bit_out2;
                ob_done = word_done2; ob_ready = word_ready2; ob_busy = busy2;
            end
            chk({tag, "_bclk"}, 32'(ob), 32'(ph >= div / 2));
            chk({tag, "_cnt"}, 32'(oc), 32'(cnt));
            chk({tag, "_bit"}, 32'(ob_bit), 32'(exp_bit));
            chk({tag, "_busy"}, 32'(ob_busy), 32'd1);
            chk({tag, "_done"}, 32'(ob_done), 32'(i == 32 * div - 1));
            chk({tag, "_ready"}, 32'(ob_ready), 32'(i == 32 * div - 1));
            if (ob && !prev_bclk) rise_cnt++;
            prev_bclk = ob;
            if (ob_done) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic clear_stats();
        rise_cnt  = 0;
        done_cnt  = 0;
        prev_bclk = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        word_in1 = '0; word_valid1 = 1'b0;
        word_in2 = '0; word_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle(0, "rst_hold1");
        rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "reset1");
        chk_idle(1, "reset2");

        // Single word, msb first: bit at counter 0 and 31 only.
        clear_stats();
        send(0, 32'h8000_0001);
        run_word(0, 32'h8000_0001, 4, 1'b1, -1, '0, 128, "t1");
        chk("t1_rises", 32'(rise_cnt), 32'd32);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_capture", cap1, 32'h8000_0001);
        chk_idle(0, "t1_after");

        // Back-to-back with word_valid held: no gap between words.
        clear_stats();
        send(0, 32'hFFFF_FFFF);
        run_word(0, 32'hFFFF_FFFF, 4, 1'b1, 0, 32'h0000_0000, 128, "t2a");
        run_word(0, 32'h0000_0000, 4, 1'b1, -1, '0, 128, "t2b");
        chk("t2_rises", 32'(rise_cnt), 32'd64);
        chk("t2_done_cnt", 32'(done_cnt), 32'd2);
        chk_idle(0, "t2_after");

        // Word offered at counter 5 waits for the last cycle, then goes out intact.
        clear_stats();
        send(0, 32'h0F0F_0F0F);
        run_word(0, 32'h0F0F_0F0F, 4, 1'b1, 20, 32'h1234_5678, 128, "t3a");
        run_word(0, 32'h1234_5678, 4, 1'b1, -1, '0, 128, "t3b");
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);
        chk("t3_capture", cap1, 32'h1234_5678);
        chk_idle(0, "t3_after");

        // Reset at counter 10, phase 2 clears outputs immediately.
        clear_stats();
        send(0, 32'hAAAA_5555);
        run_word(0, 32'hAAAA_5555, 4, 1'b1, -1, '0, 42, "t4a");
        chk("t4_pre_cnt", 32'(counter1), 32'd10);
        chk("t4_pre_bclk", 32'(bclk1), 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_bclk", 32'(bclk1), 32'd0);
        chk("t4_rst_cnt", 32'(counter1), 32'd0);
        chk("t4_rst_bit", 32'(bit_out1), 32'd0);
        chk("t4_rst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "t4_release");
        clear_stats();
        send(0, 32'h0000_0001);
        run_word(0, 32'h0000_0001, 4, 1'b1, -1, '0, 128, "t4b");
        chk("t4_rises", 32'(rise_cnt), 32'd32);
        chk("t4_capture", cap1, 32'h0000_0001);
        chk("t4_rotl7", rotl7(cap1), 32'h0000_0080);

        // lsb first, clk_div 2: 64-cycle word, bclk toggles every clk.
        clear_stats();
        send(1, 32'h0000_0001);
        run_word(1, 32'h0000_0001, 2, 1'b0, -1, '0, 64, "t5");
        chk("t5_rises", 32'(rise_cnt), 32'd32);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk_idle(1, "t5_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
